// File: rtl/dmem.sv
// dmem: word-organized data memory with byte-lane write enables and a per-word valid vector.
// Optional macro DMEM_REG_READ_EN registers outdata (1-cycle read latency, old data on read-during-write).
module dmem #(
    parameter  int DEPTH = 1024,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  we,
    input  logic [31:0] daddr,
    input  logic [31:0] indata,
    output logic [31:0] outdata
);

    logic [31:0]    mem_r [DEPTH];
    logic [DEPTH-1:0] valid_r;

    logic [AW-1:0]  idx_s;
    logic           in_range_s;
    logic           wr_en_s;
    logic [31:0]    cur_s;
    logic [31:0]    rd_s;
    logic [31:0]    merged_s;
    logic           unused_s;

    // Lanes without an enable keep the current word's byte; an invalid word contributes zeros.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lane_en);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    assign idx_s    = daddr[AW+1:2];
    assign unused_s = ^daddr[1:0];

    // Address decode, combinational read and store merge.
    always_comb begin
        in_range_s = (daddr[31:AW+2] == {(30-AW){1'b0}});
        if (valid_r[idx_s]) begin
            cur_s = mem_r[idx_s];
        end else begin
            cur_s = 32'h0000_0000;
        end
        if (in_range_s) begin
            rd_s = cur_s;
        end else begin
            rd_s = 32'h0000_0000;
        end
        wr_en_s  = !rst && in_range_s && (we != 4'b0000);
        merged_s = merge_lanes(cur_s, indata, we);
    end

    // Valid vector: cleared asynchronously, set by any accepted store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= {DEPTH{1'b0}};
        end else if (wr_en_s) begin
            valid_r[idx_s] <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Data array is never reset; invalid words are masked on read instead.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[idx_s] <= merged_s;
        end else begin
            mem_r[idx_s] <= mem_r[idx_s];
        end
    end

`ifdef DMEM_REG_READ_EN
    // Registered read port samples the pre-edge read value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outdata <= 32'h0000_0000;
        end else begin
            outdata <= rd_s;
        end
    end
`else
    assign outdata = rd_s;
`endif

endmodule

// File: tb/tb_dmem.sv
// Self-checking bench for dmem (default build, combinational read): directed plan plus randomized traffic.
module tb_dmem;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  we;
    logic [31:0] daddr;
    logic [31:0] indata;
    logic [31:0] outdata;

    int checks   = 0;
    int failures = 0;

    // Reference: flat word array, zeroed on reset; unwritten lanes of a fresh word read as zero.
    logic [31:0] ref_mem [0:1023];

    dmem #(.DEPTH(1024)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .daddr  (daddr),
        .indata (indata),
        .outdata(outdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        if (a >= 32'd4096) return 32'd0;
        return ref_mem[a / 4];
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;
    endtask

    task automatic ref_write(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        int k;
        if (a < 32'd4096) begin
            k = int'(a / 4);
            for (int i = 0; i < 4; i++) begin
                if (w[i]) ref_mem[k][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    // One clock of traffic: check old word before the edge, merged word after it.
    task automatic do_cycle(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d, input string tag);
        @(negedge clk);
        we = w; daddr = a; indata = d;
        #1;
        check_eq({tag, "_pre"}, outdata, ref_read(a));
        @(posedge clk);
        ref_write(w, a, d);
        #1;
        check_eq({tag, "_post"}, outdata, ref_read(a));
    endtask

    // Assert rst between edges with a full-word store pending; the store must be lost.
    task automatic reset_mid(input logic [31:0] a, input string tag);
        @(negedge clk);
        we = 4'hF; daddr = a; indata = $urandom;
        #2;
        rst = 1'b1;
        #1;
        ref_clear();
        check_eq({tag, "_async"}, outdata, 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_held"}, outdata, 32'd0);
        @(negedge clk);
        rst = 1'b0; we = 4'h0;
        #1;
        check_eq({tag, "_after"}, outdata, ref_read(a));
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  w;
        rst = 1'b1; we = 4'h0; daddr = 32'd0; indata = 32'd0;
        ref_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0; daddr = 32'd500;
        #1;
        check_eq("reset_read", outdata, 32'h0000_0000);

        do_cycle(4'b0001, 32'd500, 32'd250, "byte_wr1");
        check_eq("byte_wr1_const", outdata, 32'h0000_00FA);
        do_cycle(4'b0001, 32'd500, 32'd100, "byte_wr2");
        check_eq("byte_wr2_const", outdata, 32'h0000_0064);

        do_cycle(4'b0101, 32'd1000, 32'h001F_0025, "sparse");
        check_eq("sparse_const", outdata, 32'h001F_0025);
        do_cycle(4'b0011, 32'd1000, 32'd512, "half");
        check_eq("half_const", outdata, 32'h001F_0200);
        for (int i = 0; i < 3; i++) do_cycle(4'b0000, 32'd1000, 32'd100, "pure_rd");
        check_eq("pure_rd_const", outdata, 32'h001F_0200);

        do_cycle(4'b0000, 32'd1002, 32'd0, "misalign");
        check_eq("misalign_const", outdata, 32'h001F_0200);
        do_cycle(4'b1111, 32'd4096, 32'hDEAD_BEEF, "oor_wr");
        check_eq("oor_const", outdata, 32'h0000_0000);
        do_cycle(4'b0000, 32'd0, 32'd0, "oor_alias");
        check_eq("oor_alias_const", outdata, 32'h0000_0000);
        do_cycle(4'b1111, 32'd4092, 32'hDEAD_BEEF, "last_word");
        check_eq("last_word_const", outdata, 32'hDEAD_BEEF);

        reset_mid(32'd1000, "rst_mid");
        check_eq("rst_mid_const", outdata, 32'h0000_0000);
        do_cycle(4'b0000, 32'd4092, 32'd0, "rst_cleared");

        // Random traffic over a small set of words so merges and rewrites collide often.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                a = $urandom | 32'h0000_1000;
            end else if ($urandom_range(0, 7) == 0) begin
                a = 32'd4092 + 32'($urandom_range(0, 3));
            end else begin
                a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
            end
            w = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) w = 4'h0;
            do_cycle(w, a, $urandom, "rand");
            if (n % 97 == 96) reset_mid(32'($urandom_range(0, 15)) * 4, "rand_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem.md
Name: dmem

Overview:
- Data memory for the pipelined CPU's memory stage.
- Word-organized RAM with byte-lane write enables for SB/SH/SW-style stores.
- Reads are combinational; writes are synchronous on the rising clock edge.
- Asynchronous reset makes every word read back as zero.

Parameters:
- DEPTH, 1024, number of 32-bit words (4 KiB by default); power of two, at least 4.
- AW, log2(DEPTH), word-index width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock for writes.
- rst  input  1  asynchronous, active-high reset.
- we  input  4  byte-lane write enables; we[i] writes byte lane i, indata[8i+7:8i].
- daddr  input  32  byte address; word index = daddr[AW+1:2], daddr[1:0] ignored.
- indata  input  32  store data, already lane-aligned by the CPU.
- outdata  output  32  word at the addressed location.

Behaviour:
- Storage: DEPTH x 32-bit array, plus a DEPTH-bit valid vector.
  - Only the valid vector is reset: asynchronously cleared while rst=1.
  - The data array itself is not reset.
- Reads are combinational:
  - outdata = mem[idx] when valid[idx]=1, else 32'h0.
  - No clock latency.
- In range: daddr[31:AW+2] == 0.
  - Out-of-range reads return 32'h0.
  - Out-of-range writes are ignored.
- Write happens at posedge clk when rst=0, we!=0 and the address is in range.
  - Each lane with we[i]=1 takes indata byte i.
  - Each lane with we[i]=0 keeps its old byte if valid[idx]=1, else becomes 8'h00.
  - valid[idx] is then set to 1.
- we=4'b0000: no state change (pure read).
- Any we pattern is legal, including non-contiguous ones such as 4'b0101.
- Read of the address being written in the same cycle:
  - Before the edge, outdata shows the old word.
  - After the edge, it shows the merged word.
- rst asserted mid-operation:
  - outdata goes to 0 immediately, without waiting for a clock edge.
  - No writes are accepted while rst=1.
  - After release, the memory behaves as freshly zeroed.
- Misaligned daddr (daddr[1:0] != 0) is not an error; the low bits are ignored.
- Power-up without reset: contents are undefined. The bench must pulse rst first.

Optional Feature:
- Macro DMEM_REG_READ_EN.
- Defined:
  - outdata is a register, loaded at every posedge clk with the combinational read value described above.
  - That value reflects memory state before that edge's write, so read latency is 1 cycle and read-during-write returns old data.
  - The outdata register is asynchronously cleared to 0 by rst.
- Undefined: the combinational read described above.

Test Plan:
- Reset: pulse rst=1, then release; daddr=500, we=0 -> outdata=32'h00000000.
- Byte write: we=4'b0001, daddr=500, indata=250, one edge -> outdata=32'h000000FA.
  - Then indata=100, one edge -> 32'h00000064.
- Sparse lanes: we=4'b0101, daddr=1000, indata=32'h001F0025 on a zeroed word, one edge -> outdata=32'h001F0025.
- Halfword merge: then we=4'b0011, daddr=1000, indata=512, one edge -> outdata=32'h001F0200.
  - Then we=0, indata=100 for several edges -> still 32'h001F0200.
- Boundaries:
  - daddr=1002 reads the same word as daddr=1000.
  - daddr=4096 write is ignored and reads 0.
  - daddr=4092 (last word) write/read round-trips 32'hDEADBEEF.
- Async reset mid-run: assert rst between clock edges -> outdata=0 at once, and a we=4'hF write during rst is lost.
  - After release, daddr=1000 reads 0.
